ps2_rx_frame: RTL and testbench

- PS/2 device-to-host serial receiver that sits directly upstream of the keyboard scan-code FSM.
- Samples ps2c/ps2d, deglitches the clock line and shifts in 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Presents each valid byte with a one-cycle rx_done_tick; the FSM gates new frames through rx_en.
- Adds parity, framing and timeout checking so a corrupted or truncated frame never reaches the scan-code FSM.

---
 rtl/ps2_rx_frame_if.sv | 31 +++
 rtl/ps2_rx_frame.sv | 148 ++++++++++++++
 tb/tb_ps2_rx_frame.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bus: line inputs, frame enable and byte/error outputs.
// master drives the lines, slave is the receiver.
interface ps2_rx_frame_if;
  logic       rx_en;
  logic       ps2d;
  logic       ps2c;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output rx_en,
    output ps2d,
    output ps2c,
    input  rx_done_tick,
    input  dout,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  rx_en,
    input  ps2d,
    input  ps2c,
    output rx_done_tick,
    output dout,
    output parity_err,
    output frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with clock deglitch,
// parity/framing/timeout checks ahead of the scan-code FSM.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input logic           clk,
  input logic           reset,
  ps2_rx_frame_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_c;
  logic                  filt_c_n;
  logic                  fall_tick;
  logic                  d_s;

  state_t           state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] tmo, tmo_n;
  logic             discard, discard_n;
  logic [10:0]      frame, frame_n;
  logic [7:0]       dout_q, dout_n;
  logic             done_q, done_n;
  logic             perr_q, perr_n;
  logic             ferr_q, ferr_n;

  // Lines idle high, so conditioning resets to ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync  <= '1;
      d_sync  <= '1;
      filt_sr <= '1;
      filt_c  <= 1'b1;
    end else begin
      c_sync  <= {c_sync[0], bus.ps2c};
      d_sync  <= {d_sync[0], bus.ps2d};
      filt_sr <= {filt_sr[FILTER_LEN-2:0], c_sync[1]};
      filt_c  <= filt_c_n;
    end
  end

  always_comb begin
    filt_c_n = filt_c;
    if (&filt_sr)
      filt_c_n = 1'b1;
    else if (~|filt_sr)
      filt_c_n = 1'b0;
  end

  assign fall_tick = filt_c & ~filt_c_n;
  assign d_s       = d_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tmo     <= '0;
      discard <= 1'b0;
      frame   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      tmo     <= tmo_n;
      discard <= discard_n;
      frame   <= frame_n;
      dout_q  <= dout_n;
      done_q  <= done_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    tmo_n     = tmo;
    discard_n = discard;
    frame_n   = frame;
    dout_n    = dout_q;
    done_n    = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall_tick) begin
          frame_n   = {d_s, frame[10:1]};
          bit_cnt_n = 4'd9;
          discard_n = ~bus.rx_en;
          tmo_n     = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          frame_n = {d_s, frame[10:1]};
          tmo_n   = '0;
          if (bit_cnt == 4'd0)
            state_n = CHECK;
          else
            bit_cnt_n = bit_cnt - 4'd1;
        end else if (tmo == TMO_LAST) begin
          ferr_n  = ~discard;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      CHECK: begin
        // A stray fall_tick here is ignored.
        state_n = IDLE;
        if (!discard) begin
          if (frame[0] || !frame[10])
            ferr_n = 1'b1;
          else if (!(^frame[9:1]))
            perr_n = 1'b1;
          else begin
            dout_n = frame[8:1];
            done_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame with a frame-level
// expectation queue checked every cycle.
module tb_ps2_rx_frame;
  localparam int T    = 2000;
  localparam int HALF = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  ps2_rx_frame_if bus();

  ps2_rx_frame #(
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(T),
    .CNT_W(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef enum int {EV_DONE, EV_PERR, EV_FERR} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_done = 0;
  int         n_perr = 0;
  int         n_ferr = 0;
  logic [7:0] exp_dout = 8'h00;
  int         last_fall = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Outcome of a full frame from the protocol rules.
  function automatic void model(input logic [10:0] f,
                                input logic en,
                                input int t);
    exp_t e;
    if (!en) return;
    e.lo   = t + 6;
    e.hi   = t + 18;
    e.data = f[8:1];
    if (f[0] !== 1'b0 || f[10] !== 1'b1)
      e.kind = EV_FERR;
    else if ((^f[9:1]) !== 1'b1)
      e.kind = EV_PERR;
    else
      e.kind = EV_DONE;
    q.push_back(e);
  endfunction

  function automatic logic [10:0] mkf(input logic [7:0] d,
                                      input logic flip,
                                      input logic stop);
    return {stop, (~^d) ^ flip, d, 1'b0};
  endfunction

  int   npulse;
  ev_t  kind;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      npulse = int'(bus.rx_done_tick) + int'(bus.parity_err)
             + int'(bus.frame_err);
      n_done += int'(bus.rx_done_tick);
      n_perr += int'(bus.parity_err);
      n_ferr += int'(bus.frame_err);
      if (npulse > 1) begin
        chk("pulse_onehot", npulse, 1);
      end else if (npulse == 1) begin
        kind = bus.rx_done_tick ? EV_DONE :
               bus.parity_err   ? EV_PERR : EV_FERR;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got kind %0d want none",
                   kind);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", kind, e.kind);
          chk("pulse_time", cyc, (cyc >= e.lo && cyc <= e.hi) ?
              cyc : e.lo);
          if (kind == EV_DONE) exp_dout = e.data;
        end
      end
      if (q.size() > 0 && cyc > q[0].hi) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_pulse: got none want kind %0d by %0d",
                 q[0].kind, q[0].hi);
        void'(q.pop_front());
      end
      chk("dout", bus.dout, exp_dout);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] f,
                      input int n,
                      input logic en);
    bus.rx_en = en;
    for (int i = 0; i < n; i++) begin
      bus.ps2d = f[i];
      wait_cyc(HALF / 2);
      bus.ps2c = 1'b0;
      last_fall = cyc;
      if (i == 3) bus.rx_en = ~en;
      if (n == 11 && i == 10) model(f, en, cyc);
      wait_cyc(HALF);
      bus.ps2c = 1'b1;
      wait_cyc(HALF / 2);
    end
    bus.ps2d  = 1'b1;
    bus.rx_en = 1'b1;
  endtask

  initial begin
    bus.ps2c  = 1'b1;
    bus.ps2d  = 1'b1;
    bus.rx_en = 1'b1;
    reset     = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", bus.rx_done_tick, 0);
    chk("rst_perr", bus.parity_err, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_dout", bus.dout, 8'h00);
    wait_cyc(20);

    send(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(20);
    chk("t1_done", n_done, 1);
    chk("t1_dout", bus.dout, 8'h1C);
    chk("t1_err", n_perr + n_ferr, 0);

    send(mkf(8'hF0, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(20);
    chk("t2_dout_f0", bus.dout, 8'hF0);
    send(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(20);
    chk("t2_done", n_done, 3);
    chk("t2_dout_1c", bus.dout, 8'h1C);

    send(mkf(8'h1C, 1'b1, 1'b1), 11, 1'b1);
    wait_cyc(20);
    chk("t3_perr", n_perr, 1);
    chk("t3_done", n_done, 3);
    chk("t3_dout", bus.dout, 8'h1C);

    bus.ps2c = 1'b0;
    wait_cyc(3);
    bus.ps2c = 1'b1;
    wait_cyc(50);
    send(mkf(8'h29, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(20);
    chk("t4_done", n_done, 4);
    chk("t4_dout", bus.dout, 8'h29);
    chk("t4_err", n_perr + n_ferr, 1);

    send(mkf(8'h55, 1'b0, 1'b1), 5, 1'b1);
    e.kind = EV_FERR;
    e.data = 8'h00;
    e.lo   = last_fall + T;
    e.hi   = last_fall + T + 25;
    q.push_back(e);
    wait_cyc(T + 100);
    chk("t5_ferr", n_ferr, 1);
    chk("t5_dout", bus.dout, 8'h29);
    send(mkf(8'h29, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(20);
    chk("t5_done", n_done, 5);

    send(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    wait_cyc(20);
    chk("t6_drop", n_done, 5);
    chk("t6_drop_dout", bus.dout, 8'h29);
    send(mkf(8'h32, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(20);
    chk("t6_done", n_done, 6);
    chk("t6_dout", bus.dout, 8'h32);
    chk("t6_err", n_perr + n_ferr, 2);

    send(mkf(8'hA5, 1'b0, 1'b1), 7, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_dout = 8'h00;
    @(negedge clk);
    chk("t7_done", bus.rx_done_tick, 0);
    chk("t7_perr", bus.parity_err, 0);
    chk("t7_ferr", bus.frame_err, 0);
    chk("t7_dout", bus.dout, 8'h00);
    wait_cyc(20);
    send(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(30);
    chk("t7_after_done", n_done, 7);
    chk("t7_after_dout", bus.dout, 8'h1C);
    chk("t7_after_err", n_perr + n_ferr, 2);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
